// File: rtl/servo_pwm_gen.sv
// Hobby-servo PWM frame generator: one pulse per frame, width linear in an 8-bit position.
// Position, enable and slew step are latched only at frame boundaries so pulses never glitch.
module servo_pwm_gen #(
  parameter int PERIOD_CYC = 1_000_000,
  parameter int MIN_CYC    = 50_000,
  parameter int STEP_CYC   = 196,
  parameter int SLEW       = 0,
  parameter int INIT_POS   = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] pos,
  output logic       pwm_out,
  output logic       frame_start,
  output logic [7:0] cur_pos,
  output logic       at_target
);

  localparam int CW = $clog2(PERIOD_CYC);
  localparam logic [CW-1:0] LAST_CNT = CW'(PERIOD_CYC - 1);
  localparam logic [CW-1:0] MIN_W    = CW'(MIN_CYC);
  localparam logic [CW-1:0] STEP_W   = CW'(STEP_CYC);
  localparam logic [CW-1:0] INIT_W   = CW'(MIN_CYC + INIT_POS * STEP_CYC);
  localparam logic [7:0]    INIT_P   = 8'(INIT_POS);

  if (MIN_CYC + 255 * STEP_CYC >= PERIOD_CYC) begin : g_param_check
    $error("servo_pwm_gen: MIN_CYC + 255*STEP_CYC must be below PERIOD_CYC");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] width_q, width_d;
  logic [7:0]    cur_pos_q, cur_pos_d;
  logic [7:0]    target_q, target_d;
  logic          en_q, en_d;
  logic          at_target_q, at_target_d;
  logic          pwm_q, pwm_d;
  logic          frame_start_q, frame_start_d;
  logic          running_q, running_d;

  logic          boundary;
  logic [8:0]    diff;
  logic [8:0]    diff_mag;
  logic [7:0]    step_pos;

  // cnt_q holds the frame phase that the next clock edge will present on the outputs,
  // so the boundary edge (cnt_q == 0) is also the edge that launches phase 0.
  always_comb begin
    cnt_d         = (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);
    running_d     = 1'b1;
    target_d      = target_q;
    en_d          = en_q;
    cur_pos_d     = cur_pos_q;
    width_d       = width_q;
    at_target_d   = at_target_q;
    boundary      = running_q && (cnt_q == '0);

    diff     = {1'b0, pos} - {1'b0, cur_pos_q};
    diff_mag = diff[8] ? (9'd0 - diff) : diff;
    if (SLEW == 0 || int'(diff_mag) <= SLEW) begin
      step_pos = pos;
    end else if (diff[8]) begin
      step_pos = cur_pos_q - 8'(SLEW);
    end else begin
      step_pos = cur_pos_q + 8'(SLEW);
    end

    if (boundary) begin
      target_d    = pos;
      en_d        = enable;
      cur_pos_d   = step_pos;
      width_d     = MIN_W + CW'(step_pos) * STEP_W;
      at_target_d = (step_pos == pos);
    end

    frame_start_d = (cnt_q == '0);
    pwm_d         = en_d && (cnt_q < width_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      running_q     <= 1'b0;
      target_q      <= INIT_P;
      en_q          <= 1'b0;
      cur_pos_q     <= INIT_P;
      width_q       <= INIT_W;
      at_target_q   <= 1'b1;
      pwm_q         <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      running_q     <= running_d;
      target_q      <= target_d;
      en_q          <= en_d;
      cur_pos_q     <= cur_pos_d;
      width_q       <= width_d;
      at_target_q   <= at_target_d;
      pwm_q         <= pwm_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign frame_start = frame_start_q;
  assign cur_pos     = cur_pos_q;
  assign at_target   = at_target_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen: one unlimited-slew instance and one with SLEW=16,
// both sharing clock, reset and inputs; pulse widths are measured per frame.
module tb_servo_pwm_gen;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] pos;

  logic       pwm_a, fs_a, at_a;
  logic [7:0] cur_a;
  logic       pwm_b, fs_b, at_b;
  logic [7:0] cur_b;

  int checks;
  int failures;

  servo_pwm_gen #(
    .PERIOD_CYC(1000), .MIN_CYC(100), .STEP_CYC(2), .SLEW(0), .INIT_POS(128)
  ) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .pos(pos),
    .pwm_out(pwm_a), .frame_start(fs_a), .cur_pos(cur_a), .at_target(at_a)
  );

  servo_pwm_gen #(
    .PERIOD_CYC(1000), .MIN_CYC(100), .STEP_CYC(2), .SLEW(16), .INIT_POS(128)
  ) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .pos(pos),
    .pwm_out(pwm_b), .frame_start(fs_b), .cur_pos(cur_b), .at_target(at_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic en, input logic [7:0] p);
    rst    = r;
    enable = en;
    pos    = p;
  endtask

  task automatic checkOutput(input string tag, input int got, input int expected);
    checks++;
    if (got != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, expected);
    end
  endtask

  // Entered on the negedge of phase 0; returns on the negedge of the next frame's phase 0.
  // mode 1 toggles pos mid-frame and leaves 40 on the last cycle; mode 2 drops enable at phase 50.
  // A width of -1 means the pulse was not one contiguous run starting at phase 0.
  task automatic runFrame(input int mode, output int period, output int wa, output int wb);
    int  ones_a, ones_b;
    bit  run_a, run_b;
    ones_a = 0; ones_b = 0; wa = 0; wb = 0; run_a = 1'b1; run_b = 1'b1;
    period = -1;
    for (int i = 0; i < 1100; i++) begin
      if (i > 0 && fs_a) begin
        period = i;
        break;
      end
      if (pwm_a) begin ones_a++; if (run_a) wa++; end else run_a = 1'b0;
      if (pwm_b) begin ones_b++; if (run_b) wb++; end else run_b = 1'b0;
      if (mode == 1) begin
        if (i == 999) pos = 8'd40;
        else if (i % 37 == 0) pos = ~pos;
      end
      if (mode == 2 && i == 50) enable = 1'b0;
      @(negedge clk);
    end
    if (ones_a != wa) wa = -1;
    if (ones_b != wb) wb = -1;
  endtask

  initial begin
    int period, wa, wb, exp_pos;
    checks   = 0;
    failures = 0;

    applyStimulus(1'b1, 1'b1, 8'd128);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_pwm", int'(pwm_a), 0);
    checkOutput("rst_frame_start", int'(fs_a), 0);
    checkOutput("rst_cur_pos", int'(cur_a), 128);
    checkOutput("rst_at_target", int'(at_a), 1);

    rst = 1'b0;
    @(negedge clk);
    checkOutput("first_frame_start", int'(fs_a), 1);
    checkOutput("f0_cur_pos", int'(cur_a), 128);
    runFrame(0, period, wa, wb);
    checkOutput("f0_period", period, 1000);
    checkOutput("f0_silent", wa, 0);

    pos = 8'd0;
    runFrame(0, period, wa, wb);
    checkOutput("f1_period", period, 1000);
    checkOutput("f1_width_128", wa, 356);

    checkOutput("cur_pos_0", int'(cur_a), 0);
    pos = 8'd255;
    runFrame(0, period, wa, wb);
    checkOutput("width_pos0", wa, 100);

    checkOutput("cur_pos_255", int'(cur_a), 255);
    runFrame(1, period, wa, wb);
    checkOutput("width_pos255_toggling", wa, 610);
    checkOutput("toggle_period", period, 1000);

    checkOutput("cur_pos_40", int'(cur_a), 40);
    pos = 8'd128;
    runFrame(0, period, wa, wb);
    checkOutput("width_pos40", wa, 180);

    runFrame(2, period, wa, wb);
    checkOutput("width_enable_drop", wa, 356);

    runFrame(0, period, wa, wb);
    checkOutput("disabled_silent", wa, 0);
    checkOutput("disabled_period", period, 1000);

    applyStimulus(1'b0, 1'b1, 8'd200);
    runFrame(0, period, wa, wb);
    checkOutput("reenabled_still_silent", wa, 0);

    checkOutput("cur_pos_200", int'(cur_a), 200);
    repeat (200) @(negedge clk);
    checkOutput("mid_pulse_high", int'(pwm_a), 1);
    applyStimulus(1'b1, 1'b1, 8'd255);
    @(negedge clk);
    checkOutput("rst_midpulse_pwm", int'(pwm_a), 0);
    repeat (2) @(negedge clk);
    checkOutput("rst2_cur_pos", int'(cur_a), 128);
    checkOutput("rst2_at_target", int'(at_a), 1);
    checkOutput("rst2_frame_start", int'(fs_a), 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst2_first_frame_start", int'(fs_a), 1);
    checkOutput("slew_f0_cur_pos", int'(cur_b), 128);
    runFrame(0, period, wa, wb);
    checkOutput("rst2_f0_silent", wa, 0);
    checkOutput("slew_f0_silent", wb, 0);
    checkOutput("rst2_f0_period", period, 1000);

    for (int k = 1; k <= 8; k++) begin
      exp_pos = (k <= 7) ? 128 + 16 * k : 255;
      checkOutput($sformatf("slew_cur_pos_f%0d", k), int'(cur_b), exp_pos);
      checkOutput($sformatf("slew_at_target_f%0d", k), int'(at_b), (exp_pos == 255) ? 1 : 0);
      if (k == 1) checkOutput("noslew_cur_pos_f1", int'(cur_a), 255);
      runFrame(0, period, wa, wb);
      checkOutput($sformatf("slew_width_f%0d", k), wb, 100 + 2 * exp_pos);
      if (k == 1) checkOutput("noslew_width_f1", wa, 610);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
